// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM bank tester: FSM states, sweep modes and the
// per-address write pattern.
package jtsdram_pkg;

    typedef enum logic [3:0] {
        IDLE,
        GAP,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        CHK,
        ADV,
        DONE
    } state_t;

    localparam logic MODE_RO = 1'b0;
    localparam logic MODE_RW = 1'b1;

    // Callers zero-extend the address and seed, then truncate the result to the data width
    function automatic logic [63:0] pat(input logic [63:0] addr, input logic [63:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/jtsdram_rnd.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11) used for pacing gaps; exposes the low OW bits.
module jtsdram_rnd #(
    parameter int OW = 16
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          adv,
    output logic [OW-1:0] rnd
);

    logic [15:0] lfsr;

    always_ff @(posedge clk, posedge rst) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (adv)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign rnd = lfsr[OW-1:0];

endmodule

// File: rtl/jtsdram_bank_rw.sv
// SDRAM bank tester: read-verify (MODE_RO) or write-pattern-then-read (MODE_RW) sweep over 0..LAST.
// Define JTSDRAM_BANK_ERRLOG_EN to add err_addr/err_got/err_exp capture of the first mismatch.
module jtsdram_bank_rw
    import jtsdram_pkg::*;
#(
    parameter int          AW   = 22,
    parameter int          DW   = 16,
    parameter int unsigned LAST = 2**AW-1,
    parameter logic [15:0] SEED = 16'h5A3C,
    parameter int          EW   = 8
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          start,
    input  logic          mode,
    input  logic          slow,
    input  logic          LVBL,
    input  logic [DW-1:0] data_ref,
    output logic [AW-1:0] cnt_addr,
    output logic [AW-1:0] sdram_addr,
    output logic          rd,
    output logic          wr,
    output logic [DW-1:0] din,
    input  logic          ack,
    input  logic          rdy,
    input  logic [DW-1:0] data_read,
    output logic          bad,
    output logic [EW-1:0] err_cnt,
    output logic          done
`ifdef JTSDRAM_BANK_ERRLOG_EN
    ,
    output logic [AW-1:0] err_addr,
    output logic [DW-1:0] err_got,
    output logic [DW-1:0] err_exp
`endif
);

    localparam logic [AW-1:0] LAST_A = AW'(LAST);

    state_t        st;
    logic          phase_wr;
    logic          mode_q;
    logic [3:0]    gap;
    logic [3:0]    rnd4;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] pat_cur;
    logic [DW-1:0] exp_val;
    logic          pace_ok;
    logic          mismatch;

    jtsdram_rnd #(.OW(4)) u_rnd (
        .rst (rst),
        .clk (clk),
        .adv (1'b1),
        .rnd (rnd4)
    );

    assign sdram_addr = cnt_addr;
    assign pat_cur    = DW'(pat(64'(cnt_addr), 64'(SEED)));
    assign pace_ok    = slow ? (gap == 4'hf) : LVBL;
    assign exp_val    = (mode_q == MODE_RO) ? data_ref : pat_cur;
    // 4-state compare so that X/Z on the bus is reported as an error
    assign mismatch   = (rd_data !== exp_val);

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            phase_wr <= 1'b0;
            mode_q   <= MODE_RO;
            gap      <= 4'hf;
            rd_data  <= '0;
            cnt_addr <= '0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            din      <= '0;
            bad      <= 1'b0;
            err_cnt  <= '0;
            done     <= 1'b0;
`ifdef JTSDRAM_BANK_ERRLOG_EN
            err_addr <= '0;
            err_got  <= '0;
            err_exp  <= '0;
`endif
        end else if (start) begin
            // Abort anything in flight; a late rdy lands in GAP and is ignored there
            st       <= GAP;
            mode_q   <= mode;
            phase_wr <= (mode == MODE_RW);
            cnt_addr <= '0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            bad      <= 1'b0;
            err_cnt  <= '0;
            done     <= 1'b0;
`ifdef JTSDRAM_BANK_ERRLOG_EN
            err_addr <= '0;
            err_got  <= '0;
            err_exp  <= '0;
`endif
        end else begin
            case (st)
                IDLE, DONE: ;
                GAP: begin
                    if (gap != 4'hf)
                        gap <= gap + 4'd1;
                    if (pace_ok) begin
                        if (phase_wr) begin
                            wr  <= 1'b1;
                            din <= pat_cur;
                            st  <= WR_REQ;
                        end else begin
                            rd  <= 1'b1;
                            st  <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (ack) begin
                        wr <= 1'b0;
                        st <= rdy ? ADV : WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (rdy)
                        st <= ADV;
                end
                RD_REQ: begin
                    if (ack) begin
                        rd <= 1'b0;
                        if (rdy) begin
                            rd_data <= data_read;
                            st      <= CHK;
                        end else begin
                            st      <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (rdy) begin
                        rd_data <= data_read;
                        st      <= CHK;
                    end
                end
                CHK: begin
                    if (mismatch) begin
                        bad <= 1'b1;
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + 1'b1;
`ifdef JTSDRAM_BANK_ERRLOG_EN
                        if (!bad) begin
                            err_addr <= cnt_addr;
                            err_got  <= rd_data;
                            err_exp  <= exp_val;
                        end
`endif
                    end
                    st <= ADV;
                end
                ADV: begin
                    gap <= (LVBL && !slow) ? 4'hd : rnd4;
                    if (cnt_addr == LAST_A) begin
                        if (phase_wr) begin
                            phase_wr <= 1'b0;
                            cnt_addr <= '0;
                            st       <= GAP;
                        end else begin
                            done     <= 1'b1;
                            st       <= DONE;
                        end
                    end else begin
                        cnt_addr <= cnt_addr + 1'b1;
                        st       <= GAP;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
